// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: add-shift for multiply, restoring compare-subtract-shift for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
    trial = {hi_i, lo_i[WIDTH-1]};
    // trial < 2*divisor, so the sign bit of the W+1-bit difference is the restore decision
    diff  = trial - {1'b0, b_i};
    if (is_div_i) begin
      hi_o = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multi-cycle MUL/DIV producing HI/LO. Signed ops enabled by `define MULDIV_SIGNED_EN.
// Handshake: Start is taken whenever the unit is not in RUN (IDLE, or the FINISH/Done cycle);
// Busy stays high through RUN and FINISH, Done pulses for the single FINISH cycle with HI/LO valid.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept, op_div, div_zero;

  assign op_div   = (Op == OP_DIVU) || (Op == OP_DIV);
  assign div_zero = op_div && (Src_B == '0);
  assign accept   = Start && (state_q != S_RUN);

`ifdef MULDIV_SIGNED_EN
  logic signed_op, a_neg, b_neg, neg_q, rneg_q;
  assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
  assign a_neg     = signed_op & Src_A[WIDTH-1];
  assign b_neg     = signed_op & Src_B[WIDTH-1];
  assign a_mag     = a_neg ? -Src_A : Src_A;
  assign b_mag     = b_neg ? -Src_B : Src_B;
`else
  assign a_mag = Src_A;
  assign b_mag = Src_B;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .b_i      (opb_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Final result with sign fix-up, registered on the same edge that enters FINISH
  always_comb begin
    fix_hi = step_hi;
    fix_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
    if (is_div_q) begin
      if (neg_q)  fix_lo = -step_lo;
      if (rneg_q) fix_hi = -step_hi;
    end else if (neg_q) begin
      {fix_hi, fix_lo} = -{step_hi, step_lo};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end
      end
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = div_zero ? S_FINISH : S_RUN;
          cnt_d   = CNT_W'(WIDTH-1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_div_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else if (accept) begin
      is_div_q <= op_div;
      acc_hi_q <= '0;
      acc_lo_q <= op_div ? a_mag : b_mag;
      opb_q    <= op_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
`endif
      if (div_zero) begin
        hi_q  <= Src_A;
        lo_q  <= '1;
        dbz_q <= 1'b1;
      end
    end else if (state_q == S_RUN) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      if (cnt_q == '0) begin
        hi_q  <= fix_hi;
        lo_q  <= fix_lo;
        dbz_q <= 1'b0;
      end
    end
  end

  assign Busy        = (state_q != S_IDLE);
  assign Done        = (state_q == S_FINISH);
  assign Div_By_Zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule
